// File: rtl/fetch_pc_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_if
// Bundles the control inputs and status outputs of the fetch PC unit.
//   master : drives the next-PC sources (stall, trap, redirect, branch/jump,
//            call/return) and observes the fetch PC and status flags.
//   slave  : the fetch PC unit itself.
// Signals:
//   stall, trap_en, redirect_en, redirect_pc   pipeline control / flush target
//   branch_en, jmp_en, base_pc, imm            taken branch/jump and its target
//   call_en, ret_en, ret_fallback              return-address-stack control
//   pc_out, fault, ras_miss, ras_count         registered status outputs
// -----------------------------------------------------------------------------
interface fetch_pc_if #(
   parameter int DATA_WIDTH = 32,
   parameter int RAS_DEPTH  = 4
);
   localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

   logic                  stall;
   logic                  trap_en;
   logic                  redirect_en;
   logic [DATA_WIDTH-1:0] redirect_pc;
   logic                  branch_en;
   logic                  jmp_en;
   logic [DATA_WIDTH-1:0] base_pc;
   logic [DATA_WIDTH-1:0] imm;
   logic                  call_en;
   logic                  ret_en;
   logic [DATA_WIDTH-1:0] ret_fallback;
   logic [DATA_WIDTH-1:0] pc_out;
   logic                  fault;
   logic                  ras_miss;
   logic [CNT_W-1:0]      ras_count;

   modport master (
      output stall, trap_en, redirect_en, redirect_pc,
      output branch_en, jmp_en, base_pc, imm,
      output call_en, ret_en, ret_fallback,
      input  pc_out, fault, ras_miss, ras_count
   );

   modport slave (
      input  stall, trap_en, redirect_en, redirect_pc,
      input  branch_en, jmp_en, base_pc, imm,
      input  call_en, ret_en, ret_fallback,
      output pc_out, fault, ras_miss, ras_count
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Next-fetch-PC generator with a small return-address stack (RAS).
// Next-PC priority: trap > redirect > return > branch/jump > pc_out+4.
// Trap and redirect act even while stalled and clear the sticky fault flag;
// every other source is range/alignment checked and, if illegal, leaves the
// PC unchanged and sets fault. While fault is set only trap/redirect move PC.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : fetch_pc_if.slave (control inputs, pc_out/fault/ras_miss/ras_count)
// The interface instance must use the same DATA_WIDTH and RAS_DEPTH.
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
   parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100,
   parameter logic [DATA_WIDTH-1:0] PC_LIMIT    = 32'h0000_1000,
   parameter int                    RAS_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   fetch_pc_if.slave  bus
);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic                  fault_q, fault_d;
   logic                  ras_miss_q, ras_miss_d;
   logic [CNT_W-1:0]      ras_count_q, ras_count_d;
   logic [PTR_W-1:0]      ras_ptr_q, ras_ptr_d;   // next free slot; top is ptr-1
   logic [DATA_WIDTH-1:0] ras_mem_q [RAS_DEPTH];

   logic                  ras_we;
   logic [PTR_W-1:0]      ras_widx;
   logic [DATA_WIDTH-1:0] ras_wdata;

   logic [PTR_W-1:0]      top_idx;
   logic                  is_call;
   logic                  ras_empty;
   logic [DATA_WIDTH-1:0] cand;
   logic                  cand_legal;

   always_comb begin
      top_idx   = ras_ptr_q - PTR_W'(1);
      is_call   = bus.jmp_en & bus.call_en;
      ras_empty = (ras_count_q == '0);

      // Candidate from the checked (lower-priority) sources.
      if (bus.ret_en) begin
         cand = ras_empty ? bus.ret_fallback : ras_mem_q[top_idx];
      end else if (bus.branch_en | bus.jmp_en) begin
         cand = bus.base_pc + bus.imm;
      end else begin
         cand = pc_q + DATA_WIDTH'(4);
      end
      cand_legal = (cand <= PC_LIMIT) && (cand[1:0] == 2'b00);

      pc_d        = pc_q;
      fault_d     = fault_q;
      ras_miss_d  = 1'b0;
      ras_count_d = ras_count_q;
      ras_ptr_d   = ras_ptr_q;
      ras_we      = 1'b0;
      ras_widx    = ras_ptr_q;
      ras_wdata   = bus.base_pc + DATA_WIDTH'(4);

      if (bus.trap_en) begin
         // RAS left intact so execution can resume after the handler.
         pc_d    = TRAP_VECTOR;
         fault_d = 1'b0;
      end else if (bus.redirect_en) begin
         // A flush invalidates any speculative call history.
         pc_d        = bus.redirect_pc;
         fault_d     = 1'b0;
         ras_count_d = '0;
      end else if (!bus.stall && !fault_q) begin
         if (!cand_legal) begin
            fault_d = 1'b1;
         end else begin
            pc_d = cand;
            if (bus.ret_en) begin
               if (ras_empty) begin
                  ras_miss_d = 1'b1;
                  if (is_call) begin
                     // Nothing to pop, so the call becomes an ordinary push.
                     ras_we      = 1'b1;
                     ras_ptr_d   = ras_ptr_q + PTR_W'(1);
                     ras_count_d = CNT_W'(1);
                  end
               end else if (is_call) begin
                  // Pop then push collapses to replacing the top entry.
                  ras_we   = 1'b1;
                  ras_widx = top_idx;
               end else begin
                  ras_ptr_d   = top_idx;
                  ras_count_d = ras_count_q - CNT_W'(1);
               end
            end else if (is_call) begin
               // Circular pointer: a push while full overwrites the oldest.
               ras_we    = 1'b1;
               ras_ptr_d = ras_ptr_q + PTR_W'(1);
               if (ras_count_q != RAS_FULL) begin
                  ras_count_d = ras_count_q + CNT_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         fault_q     <= 1'b0;
         ras_miss_q  <= 1'b0;
         ras_count_q <= '0;
         ras_ptr_q   <= '0;
      end else begin
         pc_q        <= pc_d;
         fault_q     <= fault_d;
         ras_miss_q  <= ras_miss_d;
         ras_count_q <= ras_count_d;
         ras_ptr_q   <= ras_ptr_d;
      end
   end

   // Stack storage carries no reset; validity is tracked by ras_count_q.
   always_ff @(posedge clk) begin
      if (ras_we) begin
         ras_mem_q[ras_widx] <= ras_wdata;
      end
   end

   assign bus.pc_out    = pc_q;
   assign bus.fault     = fault_q;
   assign bus.ras_miss  = ras_miss_q;
   assign bus.ras_count = ras_count_q;

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of all PC/immediate buses.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, PC loaded on trap.
REQ-004 SHALL have parameter PC_LIMIT, default 32'h0000_1000, highest legal PC (inclusive).
REQ-005 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, minimum 2.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-008 SHALL have port stall  input  1  hold PC (pipeline stall).
REQ-009 SHALL have port trap_en  input  1  take trap to TRAP_VECTOR.
REQ-010 SHALL have port redirect_en  input  1  pipeline flush, load redirect_pc.
REQ-011 SHALL have port redirect_pc  input  DATA_WIDTH  flush target.
REQ-012 SHALL have port branch_en / jmp_en  input  1 each  taken branch / jump.
REQ-013 SHALL have port base_pc  input  DATA_WIDTH  PC of the branching instruction.
REQ-014 SHALL have port imm  input  DATA_WIDTH  branch/jump offset, two's complement.
REQ-015 SHALL have port call_en  input  1  qualifies jmp_en as a call (push return address).
REQ-016 SHALL have port ret_en  input  1  return; target popped from RAS.
REQ-017 SHALL have port ret_fallback  input  DATA_WIDTH  return target used when RAS empty.
REQ-018 SHALL have port pc_out  output  DATA_WIDTH  current fetch PC (registered).
REQ-019 SHALL have port fault  output  1  sticky illegal-target flag (registered).
REQ-020 SHALL have port ras_miss  output  1  one-cycle pulse: return with empty RAS (registered).
REQ-021 SHALL have port ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries (registered).

Function
REQ-022 Next-PC priority SHALL be: trap_en > redirect_en > ret_en > (branch_en|jmp_en) > sequential pc_out+4.
REQ-023 trap_en and redirect_en SHALL take effect even when stall=1; all lower-priority sources SHALL be ignored while stall=1 (PC, RAS, ras_miss unchanged).
REQ-024 Branch/jump target SHALL be base_pc+imm, modulo 2^DATA_WIDTH.
REQ-025 Latency: a source sampled at edge N SHALL appear on pc_out after edge N (one cycle).
REQ-026 A candidate from ret/branch/jump/sequential that is > PC_LIMIT or has bits[1:0]!=0 SHALL NOT be loaded; pc_out holds and fault sets.
REQ-027 fault SHALL remain set until a trap or redirect is taken; trap/redirect targets are loaded unchecked and clear fault.
REQ-028 While fault=1 and no trap/redirect, pc_out SHALL hold and the RAS SHALL NOT change.
REQ-029 Call (jmp_en&call_en, taken, not stalled, legal) SHALL push base_pc+4 onto the RAS; ras_count increments, saturating at RAS_DEPTH.
REQ-030 Push when full SHALL overwrite the oldest entry (circular pointer); ras_count stays RAS_DEPTH.
REQ-031 Return (taken, not stalled) SHALL load the top entry and decrement ras_count; if ras_count=0 it SHALL load ret_fallback, leave ras_count 0 and pulse ras_miss.
REQ-032 ret_en with jmp_en&call_en same cycle SHALL pop then push (top replaced by base_pc+4), ras_count unchanged; PC follows ret target.
REQ-033 Trap SHALL leave the RAS intact; redirect SHALL clear ras_count to 0.
REQ-034 branch_en/jmp_en/call_en SHALL have no effect when ret_en is taken, except REQ-032.

Reset
REQ-035 On rst=1, asynchronously: pc_out=RESET_PC, fault=0, ras_miss=0, ras_count=0, RAS pointer=0; RAS contents need not be cleared.
REQ-036 Reset asserted mid-operation SHALL override all inputs immediately; first update occurs on the first rising edge after rst deasserts.

Verification
REQ-037 Release reset, no inputs, 3 edges -> pc_out 0x0,0x4,0x8,0xC; stall=1 one edge -> pc_out holds 0xC.
REQ-038 base_pc=0x20, imm=0xFFFFFFF0, branch_en=1 -> pc_out=0x10; imm=0x2 -> pc_out holds, fault=1; redirect_pc=0x40 -> pc_out=0x40, fault=0.
REQ-039 Five calls at base_pc 0x10,0x20,0x30,0x40,0x50 (RAS_DEPTH=4) -> ras_count=4; four returns -> pc_out 0x54,0x44,0x34,0x24; fifth return with ret_fallback=0x80 -> pc_out=0x80, ras_miss one cycle.
REQ-040 stall=1 with trap_en=1 and branch_en=1 -> pc_out=0x100, RAS unchanged; stall=1 with only ret_en -> no pop.
REQ-041 ret_en with jmp_en&call_en, base_pc=0x60, RAS top 0x24, count 2 -> pc_out=0x24, top becomes 0x64, ras_count=2.
REQ-042 Assert rst between edges mid-sequence -> pc_out=0x0, ras_count=0, fault=0 without a clock edge.
